memarb: RTL
===========

MEMARB -- requirements
Module: memarb

Interface
REQ-001 Parameter ADDR_W, default 24, memory address width.
REQ-002 Parameter DATA_W, default 24, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 3, the number of consecutive instruction-port denials that forces an instruction grant.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 i_req / i_addr  in  1 / ADDR_W  instruction-fetch read request and address.
REQ-008 i_gnt / i_rvalid / i_rdata  out  1 / 1 / DATA_W  instruction grant, read valid and read data.
REQ-009 d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, address and write data.
REQ-010 d_gnt / d_rvalid / d_rdata  out  1 / 1 / DATA_W  data-port grant, read valid and read data.
REQ-011 mem_addr / mem_we / mem_wdata  out  ADDR_W / 1 / DATA_W  shared single-port memory address, write enable and write data.
REQ-012 mem_rdata  in  DATA_W  memory read data, valid one cycle after its address.
REQ-013 stat_i / stat_d / stat_conflict  out  16 each  statistics counters (see Configuration).

Function
REQ-014 At most one of i_gnt and d_gnt SHALL be high in any cycle.
REQ-015 Grants are combinational in the request cycle: mem_addr is driven by the granted port's address.
REQ-016 mem_we SHALL equal d_gnt AND d_we; mem_wdata SHALL equal d_wdata.
REQ-017 With no grant: mem_addr = 0 and mem_we = 0.
REQ-018 Requesters hold req and all payload stable until gnt is sampled high; the arbiter never drops an asserted request.
REQ-019 Only i_req: i_gnt = 1. Only d_req: d_gnt = 1.
REQ-020 Both requesting: d_gnt = 1, unless starve_cnt == STARVE_LIMIT, in which case i_gnt = 1.
REQ-021 starve_cnt: cleared on any i_gnt; incremented when i_req = 1 and i_gnt = 0; saturates at STARVE_LIMIT; cleared when i_req = 0.
REQ-022 Read response tag register: states NONE, INSTR, DATA.
  - Next state is INSTR on an i_gnt cycle.
  - Next state is DATA on a d_gnt cycle with d_we = 0.
  - Next state is NONE otherwise, including data writes.
REQ-023 Read latency is exactly 1 cycle: tag INSTR gives i_rvalid = 1 and i_rdata = mem_rdata; tag DATA gives d_rvalid = 1 and d_rdata = mem_rdata.
REQ-024 The unselected rdata output SHALL be 0.
REQ-025 Back-to-back grants SHALL be accepted every cycle; a response and a new grant may coincide.
REQ-026 Writes produce no rvalid.

Reset
REQ-027 While rst is high: gnts = 0, rvalids = 0, rdata = 0, mem_we = 0, tag = NONE, starve_cnt = 0, stat counters = 0.
REQ-028 A read granted in the cycle rst is asserted SHALL produce no rvalid afterwards.
REQ-029 The first grant is possible in the first cycle with rst low.

Configuration
REQ-030 The macro MEMARB_STATS_EN controls the statistics counters.
REQ-031 With MEMARB_STATS_EN defined:
  - stat_i counts i_gnt cycles.
  - stat_d counts d_gnt cycles.
  - stat_conflict counts cycles with i_req AND d_req.
  - All three are 16-bit, saturate at 0xFFFF, and clear on rst.
REQ-032 Without MEMARB_STATS_EN, stat_* SHALL be constant 0 and no counter flops are generated.

Structure
REQ-033 The tag encodings (NONE = 0, INSTR = 1, DATA = 2) and the STARVE_LIMIT default SHALL live in the shared core package/header.
REQ-034 One sub-module, memarb_pick, SHALL hold the combinational grant selection; inputs are i_req, d_req and starve_cnt; outputs are i_gnt and d_gnt.
REQ-035 The tag, starve counter and statistics SHALL stay in memarb.

Verification
REQ-036 i_req = 1 at 0x000010 alone -> i_gnt the same cycle; next cycle i_rvalid = 1, i_rdata = memory[0x10].
REQ-037 d_req = 1, d_we = 1, addr 0x20, data 0xABCDEF -> mem_we = 1 that cycle, no d_rvalid; a later read of 0x20 returns 0xABCDEF after 1 cycle.
REQ-038 i_req and d_req (reads) held continuously with STARVE_LIMIT = 3 -> grant pattern D, D, D, I repeating; each rvalid goes to the correct port.
REQ-039 Alternating I and D reads on consecutive cycles -> one grant and one response per cycle, with zero bubbles.
REQ-040 rst asserted in the cycle of a d read grant -> d_rvalid stays 0 the next cycle; all outputs match REQ-027.
REQ-041 With MEMARB_STATS_EN: 10 conflict cycles -> stat_conflict = 10, stat_i + stat_d = 10. Without the macro: all stat_* = 0.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: response tags,
// starvation default and counter helpers.
package memarb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_INSTR = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  localparam int STARVE_LIMIT_DEF = 3;
  localparam int STAT_W           = 16;

  // Width needed to hold 0..limit; never narrower than one bit.
  function automatic int starve_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/memarb_pick.sv
// Purpose: combinational grant pick between instruction and data requesters.
// Latency: zero cycles, pure combinational.
// Backpressure: a denied requester simply sees gnt low and holds its request.
module memarb_pick #(
  parameter int               CNT_W = 2,
  parameter logic [CNT_W-1:0] LIMIT = 2'd3
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             i_gnt,
  output logic             d_gnt
);

  logic starved;

  // Data wins contention unless the instruction side has waited its limit.
  assign starved = (starve_cnt == LIMIT);
  assign i_gnt   = i_req & (~d_req | starved);
  assign d_gnt   = d_req & ~i_gnt;

endmodule

// File: rtl/memarb.sv
// Purpose: arbitrate an instruction and a data port onto one single-port memory;
// latency: grant in request cycle, read data one cycle later; backpressure: denied req held.
// Optional statistics counters are built only when MEMARB_STATS_EN is defined.
module memarb
  import memarb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_i,
  output logic [STAT_W-1:0] stat_d,
  output logic [STAT_W-1:0] stat_conflict
);

  localparam int               CNT_W = starve_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             pick_i;
  logic             pick_d;
  tag_e             tag_q;
  tag_e             tag_d;

  memarb_pick #(
    .CNT_W (CNT_W),
    .LIMIT (LIMIT)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .i_gnt      (pick_i),
    .d_gnt      (pick_d)
  );

  // Reset masks grants so nothing issued during reset can produce a response.
  assign i_gnt = pick_i & ~rst;
  assign d_gnt = pick_d & ~rst;

  assign mem_addr  = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
  assign mem_we    = d_gnt & d_we;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (i_gnt) begin
      tag_d = TAG_INSTR;
    end else if (d_gnt && !d_we) begin
      tag_d = TAG_DATA;
    end
  end

  assign i_rvalid = ~rst & (tag_q == TAG_INSTR);
  assign d_rvalid = ~rst & (tag_q == TAG_DATA);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef MEMARB_STATS_EN
  logic [STAT_W-1:0] cnt_i;
  logic [STAT_W-1:0] cnt_d;
  logic [STAT_W-1:0] cnt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i <= '0;
      cnt_d <= '0;
      cnt_c <= '0;
    end else begin
      if (i_gnt) cnt_i <= sat_inc(cnt_i);
      if (d_gnt) cnt_d <= sat_inc(cnt_d);
      if (i_req && d_req) cnt_c <= sat_inc(cnt_c);
    end
  end

  assign stat_i        = rst ? '0 : cnt_i;
  assign stat_d        = rst ? '0 : cnt_d;
  assign stat_conflict = rst ? '0 : cnt_c;
`else
  assign stat_i        = '0;
  assign stat_d        = '0;
  assign stat_conflict = '0;
`endif

endmodule
